oserdes_tx_sched: RTL and testbench
===================================

// Module: oserdes_tx_sched
// PURPOSE
// Word-rate scheduler feeding one OSERDES. Sits in the CLKDIV domain and drives D1..D6, T1..T4, OCE and TCE.
// Shares the serializer between two burst requesters (round-robin) and a training-pattern request.
// Inserts tristate turnaround guard words around every burst and fills underruns with an idle word.
// PARAMETERS
// DATA_WIDTH      4          parallel data bits used (2..6); D bits above DATA_WIDTH are driven 0
// TRISTATE_WIDTH  4          tristate bits used (1 or 4); T bits above TRISTATE_WIDTH are driven 1
// IDLE_WORD       6'b000000  data word sent during guard/underrun cycles
// TRAIN_WORD      6'b101010  data word repeated during training
// TRAIN_WORDS     16         training length in words (1..255)
// GUARD_WORDS     2          driven idle words before and after each burst (1..15)
// PORTS
// CLK         in   1  word clock (same clock as OSERDES CLKDIV)
// SR          in   1  reset, asynchronous, active-high
// TRAIN_REQ   in   1  level; request a training sequence
// REQ0/REQ1   in   1  requester n has a word valid
// DIN0/DIN1   in   6  requester n data word
// LAST0/LAST1 in   1  qualifies DIN: final word of burst
// GNT0/GNT1   out  1  ready to requester n; transfer = REQn & GNTn
// D           out  6  to OSERDES D6..D1 (D[0]=D1)
// T           out  4  to OSERDES T4..T1 (1 = high-Z)
// OCE/TCE     out  1  OSERDES clock enables
// BUSY        out  1  state != IDLE
// TRAIN_DONE  out  1  one-cycle pulse on last training word
// UNDERRUN    out  1  one-cycle pulse per idle word inserted mid-burst
// BEHAVIOUR
// - Reset (async, immediate, also mid-burst): D=0, T=4'hF, OCE=0, TCE=0, GNT*=0, BUSY=1, pulses=0, state=HOLD, rr pointer=0.
// - All outputs except GNT* are registered. GNTn is combinational: (state==BURST) & (owner==n) & ~last_taken.
// - HOLD: 2 cycles after SR deasserts, outputs at reset values; then OCE=TCE=1 permanently, -> IDLE.
// - IDLE: D=IDLE_WORD, T=all 1. Priority: TRAIN_REQ > round-robin REQ0/REQ1.
//   TRAIN_REQ -> TRAIN; else single REQ wins; both REQ: winner = ~rr pointer's last grant; -> GUARD_ON, owner latched.
// - TRAIN: T=0, D=TRAIN_WORD for exactly TRAIN_WORDS cycles; TRAIN_DONE on the last; -> IDLE. TRAIN_REQ still high
//   at exit starts a new sequence only after one IDLE cycle.
// - GUARD_ON: T=0, D=IDLE_WORD for GUARD_WORDS cycles; -> BURST.
// - BURST: transfer in cycle n -> D=DINowner, T=0 in cycle n+1 (latency 1). No transfer (REQ low) -> D=IDLE_WORD, T=0,
//   UNDERRUN=1. Transfer with LAST -> GUARD_OFF, GNT drops the next cycle; rr pointer records owner.
// - GUARD_OFF: T=0, D=IDLE_WORD for GUARD_WORDS cycles; -> IDLE (T=all 1 from the first IDLE cycle).
// - TRAIN_REQ during GUARD_ON/BURST/GUARD_OFF is not pre-empting; serviced at next IDLE before pending REQs.
// - Non-owner REQ during a burst is ignored (GNT=0) and wins next arbitration if still asserted.
// - Guard and train counters saturate at their terminal value; no wrap. Bits D[5:DATA_WIDTH] always 0.
// TESTING
// 1 SR pulse mid-burst -> same edge D=0, T=F, GNT0=0; OCE=TCE=1 exactly 3 CLK after SR falls; then IDLE.
// 2 TRAIN_REQ 1 cycle, TRAIN_WORDS=16 -> 16 cycles D=6'b101010 T=0, TRAIN_DONE on 16th, then T=F.
// 3 REQ0 burst 3 words A,B,C(LAST), GUARD_WORDS=2 -> T=0 for 7 cycles: idle,idle,A,B,C,idle,idle; each word 1 cycle after GNT0 transfer.
// 4 REQ0,REQ1 both held from reset, 1-word bursts -> grants alternate 0,1,0,1 with guard words between.
// 5 REQ0 drops 2 cycles mid-burst -> 2 IDLE_WORD with T=0, 2 UNDERRUN pulses, burst resumes, no T=1 gap.
// 6 TRAIN_REQ and REQ1 asserted during REQ0 burst -> after GUARD_OFF: training runs first, then REQ1 burst.

Source files
------------

// File: rtl/oserdes_tx_sched.sv
// Word-rate scheduler for one OSERDES: arbitrates two burst requesters and a training request,
// wrapping each burst in tristate guard words and padding underruns with the idle word.
module oserdes_tx_sched #(
    parameter int         DATA_WIDTH     = 4,
    parameter int         TRISTATE_WIDTH = 4,
    parameter logic [5:0] IDLE_WORD      = 6'b000000,
    parameter logic [5:0] TRAIN_WORD     = 6'b101010,
    parameter int         TRAIN_WORDS    = 16,
    parameter int         GUARD_WORDS    = 2
) (
    input  logic       clk_i,
    input  logic       sr_i,
    input  logic       train_req_i,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic [5:0] din0_i,
    input  logic [5:0] din1_i,
    input  logic       last0_i,
    input  logic       last1_i,
    output logic       gnt0_o,
    output logic       gnt1_o,
    output logic [5:0] d_o,
    output logic [3:0] t_o,
    output logic       oce_o,
    output logic       tce_o,
    output logic       busy_o,
    output logic       train_done_o,
    output logic       underrun_o
);

    function automatic logic [5:0] lsb_mask(input int w);
        logic [5:0] m;
        m = '0;
        for (int i = 0; i < 6; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [5:0] D_MASK     = lsb_mask(DATA_WIDTH);
    localparam logic [5:0] T_MASK6    = lsb_mask(TRISTATE_WIDTH);
    localparam logic [3:0] T_ON       = ~T_MASK6[3:0];
    localparam logic [5:0] IDLE_D     = IDLE_WORD & D_MASK;
    localparam logic [5:0] TRAIN_D    = TRAIN_WORD & D_MASK;
    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_WORDS - 1);
    localparam logic [7:0] TRAIN_LOAD = 8'(TRAIN_WORDS - 1);

    // state     | meaning
    // HOLD      | post-reset settle, serializer clock enables still off
    // IDLE      | lines released (T=1), arbitrating
    // TRAIN     | training pattern, lines driven
    // GUARD_ON  | driven idle words before a burst
    // BURST     | owner's words forwarded, idle word on underrun
    // GUARD_OFF | driven idle words after a burst
    typedef enum logic [2:0] {
        S_HOLD, S_IDLE, S_TRAIN, S_GUARD_ON, S_BURST, S_GUARD_OFF
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] hold_q, hold_d;
    logic       owner_q, owner_d;
    logic       rr_q, rr_d;
    logic       train_pend_q, train_pend_d;
    logic [5:0] d_q, d_d;
    logic [3:0] t_q, t_d;
    logic       oce_q, oce_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       und_q, und_d;

    logic       xfer;
    logic       last_sel;
    logic [5:0] din_sel;
    logic       cnt_zero;
    logic       train_want;

    assign din_sel    = owner_q ? din1_i : din0_i;
    assign last_sel   = owner_q ? last1_i : last0_i;
    assign xfer       = (state_q == S_BURST) && (owner_q ? req1_i : req0_i);
    assign cnt_zero   = (cnt_q == 8'd0);
    assign train_want = train_req_i || train_pend_q;

    always_ff @(posedge clk_i or posedge sr_i) begin
        if (sr_i) begin
            state_q      <= S_HOLD;
            cnt_q        <= '0;
            hold_q       <= 2'd2;
            owner_q      <= 1'b0;
            rr_q         <= 1'b0;
            train_pend_q <= 1'b0;
            d_q          <= '0;
            t_q          <= 4'hF;
            oce_q        <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            und_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            train_pend_q <= train_pend_d;
            d_q          <= d_d;
            t_q          <= t_d;
            oce_q        <= oce_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            und_q        <= und_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        hold_d       = hold_q;
        train_pend_d = train_pend_q;
        unique case (state_q)
            S_HOLD: begin
                if (hold_q == 2'd0) state_d = S_IDLE;
                else                hold_d  = hold_q - 2'd1;
            end
            S_IDLE: begin
                if (train_want) begin
                    state_d = S_TRAIN;
                end else if (req0_i || req1_i) begin
                    state_d = S_GUARD_ON;
                    // rr_q holds the requester preferred when both ask
                    owner_d = (req0_i && req1_i) ? rr_q : req1_i;
                end
            end
            S_TRAIN:     if (cnt_zero) state_d = S_IDLE;
            S_GUARD_ON:  if (cnt_zero) state_d = S_BURST;
            S_BURST: begin
                if (xfer && last_sel) begin
                    state_d = S_GUARD_OFF;
                    rr_d    = ~owner_q;
                end
            end
            S_GUARD_OFF: if (cnt_zero) state_d = S_IDLE;
            default:     state_d = S_HOLD;
        endcase

        // Training requests arriving outside TRAIN wait for the next IDLE
        if (state_q != S_TRAIN && train_req_i) train_pend_d = 1'b1;
        if (state_d == S_TRAIN)                train_pend_d = 1'b0;

        cnt_d = cnt_zero ? cnt_q : cnt_q - 8'd1;
        if (state_d != state_q) begin
            if (state_d == S_TRAIN)                                 cnt_d = TRAIN_LOAD;
            else if (state_d == S_GUARD_ON || state_d == S_GUARD_OFF) cnt_d = GUARD_LOAD;
        end
    end

    // Output words are registered one cycle behind the state that produced them
    always_comb begin
        d_d    = IDLE_D;
        t_d    = 4'hF;
        und_d  = 1'b0;
        done_d = 1'b0;
        oce_d  = oce_q || (state_d != S_HOLD);
        busy_d = (state_d != S_IDLE);
        unique case (state_q)
            S_HOLD:  d_d = '0;
            S_IDLE:  ;
            S_TRAIN: begin
                d_d    = TRAIN_D;
                t_d    = T_ON;
                done_d = cnt_zero;
            end
            S_GUARD_ON, S_GUARD_OFF: t_d = T_ON;
            S_BURST: begin
                t_d = T_ON;
                if (xfer) d_d   = din_sel & D_MASK;
                else      und_d = 1'b1;
            end
            default: d_d = '0;
        endcase
    end

    assign gnt0_o       = (state_q == S_BURST) && !owner_q;
    assign gnt1_o       = (state_q == S_BURST) &&  owner_q;
    assign d_o          = d_q;
    assign t_o          = t_q;
    assign oce_o        = oce_q;
    assign tce_o        = oce_q;
    assign busy_o       = busy_q;
    assign train_done_o = done_q;
    assign underrun_o   = und_q;

endmodule

// File: tb/tb_oserdes_tx_sched.sv
// Directed bench for oserdes_tx_sched: requester models feed word queues, a scoreboard holds the
// expected driven-word stream (T != all-ones) and a negedge monitor pops and compares it.
module tb_oserdes_tx_sched;

    localparam int         GW      = 2;
    localparam int         TRW     = 16;
    localparam logic [5:0] IDLE_W  = 6'b000000;
    localparam logic [5:0] TRAIN_W = 6'b101010;
    localparam logic [5:0] DMASK   = 6'b001111;

    logic       clk_i = 1'b0;
    logic       sr_i = 1'b0;
    logic       train_req_i = 1'b0;
    logic       req0_i = 1'b0, req1_i = 1'b0;
    logic [5:0] din0_i = '0, din1_i = '0;
    logic       last0_i = 1'b0, last1_i = 1'b0;
    logic       gnt0_o, gnt1_o;
    logic [5:0] d_o;
    logic [3:0] t_o;
    logic       oce_o, tce_o, busy_o, train_done_o, underrun_o;

    oserdes_tx_sched #(
        .DATA_WIDTH(4), .TRISTATE_WIDTH(4), .IDLE_WORD(IDLE_W), .TRAIN_WORD(TRAIN_W),
        .TRAIN_WORDS(TRW), .GUARD_WORDS(GW)
    ) dut (
        .clk_i(clk_i), .sr_i(sr_i), .train_req_i(train_req_i),
        .req0_i(req0_i), .req1_i(req1_i), .din0_i(din0_i), .din1_i(din1_i),
        .last0_i(last0_i), .last1_i(last1_i), .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
        .d_o(d_o), .t_o(t_o), .oce_o(oce_o), .tce_o(tce_o), .busy_o(busy_o),
        .train_done_o(train_done_o), .underrun_o(underrun_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic [5:0] d; logic [3:0] t; logic und; logic done; } obs_t;
    typedef struct packed { logic [5:0] data; logic last; logic gap; } src_t;

    obs_t exp_q[$];
    src_t q0[$], q1[$];
    bit   take0 = 1'b0, take1 = 1'b0;
    int   total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic push_exp(input logic [5:0] d, input logic und, input logic done);
        exp_q.push_back({d & DMASK, 4'h0, und, done});
    endtask

    task automatic push_guard();
        repeat (GW) push_exp(IDLE_W, 1'b0, 1'b0);
    endtask

    task automatic push_train();
        for (int i = 0; i < TRW; i++) push_exp(TRAIN_W, 1'b0, i == TRW - 1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_gnt0(input int budget);
        int n = 0;
        while (!gnt0_o && n < budget) begin
            tick();
            n++;
        end
        chk("gnt0_seen", 32'(gnt0_o), 32'd1);
    endtask

    task automatic check_oce_timing();
        tick(); chk("oce_edge1", 32'({oce_o, tce_o}), 32'd0);
        tick(); chk("oce_edge2", 32'({oce_o, tce_o}), 32'd0);
        tick(); chk("oce_edge3", 32'({oce_o, tce_o}), 32'h3);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_t", 32'(t_o), 32'hF);
    endtask

    // Scoreboard monitor
    initial forever begin
        obs_t e;
        @(negedge clk_i);
        take0 = gnt0_o && (q0.size() > 0);
        take1 = gnt1_o && (q1.size() > 0);
        if (!sr_i) begin
            if (t_o != 4'hF) begin
                chk("stream_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("stream", 32'({d_o, t_o, underrun_o, train_done_o}), 32'(e));
                end
            end else begin
                chk("released_pulses", 32'({underrun_o, train_done_o}), 32'd0);
            end
        end
    end

    // Requester models; a gap entry holds REQ low for one granted cycle
    initial forever begin
        @(posedge clk_i);
        #1;
        if (take0 && q0.size() > 0) q0.delete(0);
        if (q0.size() > 0) begin
            req0_i = !q0[0].gap; din0_i = q0[0].data; last0_i = q0[0].last;
        end else begin
            req0_i = 1'b0; din0_i = '0; last0_i = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk_i);
        #1;
        if (take1 && q1.size() > 0) q1.delete(0);
        if (q1.size() > 0) begin
            req1_i = !q1[0].gap; din1_i = q1[0].data; last1_i = q1[0].last;
        end else begin
            req1_i = 1'b0; din1_i = '0; last1_i = 1'b0;
        end
    end

    initial begin
        #1 sr_i = 1'b1;
        #1;
        chk("rst_d", 32'(d_o), 32'd0);
        chk("rst_t", 32'(t_o), 32'hF);
        chk("rst_oce_tce", 32'({oce_o, tce_o}), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_gnt", 32'({gnt0_o, gnt1_o}), 32'd0);
        chk("rst_pulses", 32'({underrun_o, train_done_o}), 32'd0);

        // Both requesters held from reset, one-word bursts: order 0,1,0,1
        q0.push_back({6'h31, 1'b1, 1'b0}); q0.push_back({6'h32, 1'b1, 1'b0});
        q1.push_back({6'h25, 1'b1, 1'b0}); q1.push_back({6'h26, 1'b1, 1'b0});
        push_guard(); push_exp(6'h31, 0, 0); push_guard();
        push_guard(); push_exp(6'h25, 0, 0); push_guard();
        push_guard(); push_exp(6'h32, 0, 0); push_guard();
        push_guard(); push_exp(6'h26, 0, 0); push_guard();
        tick(); tick();
        sr_i = 1'b0;
        check_oce_timing();
        wait_drain(300);
        repeat (3) tick();
        chk("after_rr_busy", 32'(busy_o), 32'd0);

        // Three-word burst
        q0.push_back({6'h3A, 1'b0, 1'b0});
        q0.push_back({6'h1B, 1'b0, 1'b0});
        q0.push_back({6'h2C, 1'b1, 1'b0});
        push_guard(); push_exp(6'h3A, 0, 0); push_exp(6'h1B, 0, 0); push_exp(6'h2C, 0, 0); push_guard();
        wait_drain(100);
        tick();

        // Two-cycle underrun mid-burst
        q0.push_back({6'h01, 1'b0, 1'b0});
        q0.push_back({6'h02, 1'b0, 1'b0});
        q0.push_back({6'h00, 1'b0, 1'b1});
        q0.push_back({6'h00, 1'b0, 1'b1});
        q0.push_back({6'h03, 1'b0, 1'b0});
        q0.push_back({6'h04, 1'b1, 1'b0});
        push_guard(); push_exp(6'h01, 0, 0); push_exp(6'h02, 0, 0);
        push_exp(IDLE_W, 1, 0); push_exp(IDLE_W, 1, 0);
        push_exp(6'h03, 0, 0); push_exp(6'h04, 0, 0); push_guard();
        wait_drain(100);
        repeat (2) tick();

        // Single-cycle training request
        train_req_i = 1'b1;
        push_train();
        tick();
        train_req_i = 1'b0;
        tick();
        chk("train_busy", 32'(busy_o), 32'd1);
        wait_drain(100);
        tick();
        chk("train_exit_t", 32'(t_o), 32'hF);

        // Training and REQ1 arrive during a REQ0 burst
        for (int i = 1; i <= 4; i++) q0.push_back({6'(6'h10 + i), i == 4, 1'b0});
        push_guard();
        for (int i = 1; i <= 4; i++) push_exp(6'(6'h10 + i), 0, 0);
        push_guard();
        push_train();
        push_guard(); push_exp(6'h2D, 0, 0); push_guard();
        wait_gnt0(50);
        train_req_i = 1'b1;
        q1.push_back({6'h2D, 1'b1, 1'b0});
        tick();
        train_req_i = 1'b0;
        chk("nonowner_gnt", 32'({gnt0_o, gnt1_o}), 32'h2);
        wait_drain(200);
        repeat (3) tick();

        // Reset pulse in the middle of a burst
        for (int i = 0; i < 6; i++) q0.push_back({6'(6'h20 + i), i == 5, 1'b0});
        push_guard();
        for (int i = 0; i < 6; i++) push_exp(6'(6'h20 + i), 0, 0);
        push_guard();
        wait_gnt0(50);
        tick(); tick();
        sr_i = 1'b1;
        #1;
        chk("sr_d", 32'(d_o), 32'd0);
        chk("sr_t", 32'(t_o), 32'hF);
        chk("sr_gnt0", 32'(gnt0_o), 32'd0);
        chk("sr_oce", 32'({oce_o, tce_o}), 32'd0);
        chk("sr_busy", 32'(busy_o), 32'd1);
        exp_q.delete();
        q0.delete();
        #1 sr_i = 1'b0;
        check_oce_timing();

        repeat (5) tick();
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        chk("final_busy", 32'(busy_o), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
